// File: rtl/chacha_aead_job_sequencer.sv
// -----------------------------------------------------------------------------
// chacha_aead_job_sequencer
//
// Drives one chacha20_poly1305_core through a complete AEAD job:
// init, N data blocks, done, tag. A job descriptor is accepted in IDLE, the
// data blocks stream in and out one at a time, and the job ends with a
// 128-bit tag. A watchdog aborts the job when the core stops answering.
//
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   job_*                    descriptor (key, nonce, encdec, nblocks) + handshake
//   in_valid/in_ready/in_data      input block stream
//   out_valid/out_ready/out_data   processed block stream
//   tag_valid/tag_ready/tag_out/tag_err   final tag (tag_err = watchdog abort)
//   busy, blk_cnt            status: not idle / blocks completed this job
//   core_init/next/done      one-cycle command pulses to the core
//   core_encdec/key/nonce/data_in  operands to the core
//   core_ready/valid/tag_ok, core_data_out, core_tag   core responses
//   dbg_state                current FSM state
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. Once raised, valid and its payload stay unchanged
// until that transfer; ready may be raised independently of valid.
// -----------------------------------------------------------------------------
module chacha_aead_job_sequencer #(
    parameter int NB_W    = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            job_valid,
    output logic            job_ready,
    input  logic [255:0]    job_key,
    input  logic [95:0]     job_nonce,
    input  logic            job_encdec,
    input  logic [NB_W-1:0] job_nblocks,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [511:0]    in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [511:0]    out_data,
    output logic            tag_valid,
    input  logic            tag_ready,
    output logic [127:0]    tag_out,
    output logic            tag_err,
    output logic            busy,
    output logic [NB_W-1:0] blk_cnt,
    output logic            core_init,
    output logic            core_next,
    output logic            core_done,
    output logic            core_encdec,
    output logic [255:0]    core_key,
    output logic [95:0]     core_nonce,
    output logic [511:0]    core_data_in,
    input  logic            core_ready,
    input  logic            core_valid,
    input  logic            core_tag_ok,
    input  logic [511:0]    core_data_out,
    input  logic [127:0]    core_tag,
    output logic [3:0]      dbg_state
);

    localparam int              WD_W    = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_INIT      = 4'd1,
        S_WAIT_INIT = 4'd2,
        S_FEED      = 4'd3,
        S_WAIT_BLK  = 4'd4,
        S_DRAIN     = 4'd5,
        S_FINAL     = 4'd6,
        S_WAIT_TAG  = 4'd7,
        S_TAG_OUT   = 4'd8
    } state_t;

    state_t          r_state, w_next;
    logic [NB_W-1:0] r_rem, w_rem_next;
    logic [WD_W-1:0] r_wd_cnt;
    logic            w_waiting, w_resp, w_expire;

    logic            r_job_ready, r_in_ready, r_out_valid, r_tag_valid, r_tag_err;
    logic            r_busy, r_core_init, r_core_next, r_core_done, r_core_encdec;
    logic [NB_W-1:0] r_blk_cnt;
    logic [255:0]    r_core_key;
    logic [95:0]     r_core_nonce;
    logic [511:0]    r_core_data_in, r_out_data;
    logic [127:0]    r_tag_out;

    assign w_expire = (r_wd_cnt == WD_LAST);

    // A command pulse is visible for one cycle after the state that issues it;
    // a response seen during that pulse cycle predates the command and is
    // ignored.
    always_comb begin
        w_next     = r_state;
        w_rem_next = r_rem;
        w_waiting  = 1'b0;
        w_resp     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (job_valid) begin
                    w_next     = S_INIT;
                    w_rem_next = job_nblocks;
                end
            end
            S_INIT: begin
                if (core_ready) w_next = S_WAIT_INIT;
            end
            S_WAIT_INIT: begin
                w_waiting = 1'b1;
                w_resp    = core_ready && !r_core_init;
                if (w_resp)        w_next = S_FEED;
                else if (w_expire) w_next = S_TAG_OUT;
            end
            S_FEED: begin
                if (r_rem == '0)                  w_next = S_FINAL;
                else if (in_valid && r_in_ready)  w_next = S_WAIT_BLK;
            end
            S_WAIT_BLK: begin
                w_waiting = 1'b1;
                w_resp    = core_valid && !r_core_next;
                if (w_resp)        w_next = S_DRAIN;
                else if (w_expire) w_next = S_TAG_OUT;
            end
            S_DRAIN: begin
                if (out_ready) begin
                    w_next     = S_FEED;
                    w_rem_next = r_rem - NB_W'(1);
                end
            end
            S_FINAL: begin
                w_next = S_WAIT_TAG;
            end
            S_WAIT_TAG: begin
                w_waiting = 1'b1;
                w_resp    = core_tag_ok && !r_core_done;
                if (w_resp || w_expire) w_next = S_TAG_OUT;
            end
            S_TAG_OUT: begin
                if (tag_ready) w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_job_ready    <= 1'b1;
            r_in_ready     <= 1'b0;
            r_out_valid    <= 1'b0;
            r_tag_valid    <= 1'b0;
            r_tag_err      <= 1'b0;
            r_busy         <= 1'b0;
            r_core_init    <= 1'b0;
            r_core_next    <= 1'b0;
            r_core_done    <= 1'b0;
            r_core_encdec  <= 1'b0;
            r_blk_cnt      <= '0;
            r_rem          <= '0;
            r_wd_cnt       <= '0;
            r_core_key     <= '0;
            r_core_nonce   <= '0;
            r_core_data_in <= '0;
            r_out_data     <= '0;
            r_tag_out      <= '0;
        end else begin
            r_job_ready <= (w_next == S_IDLE);
            r_busy      <= (w_next != S_IDLE);
            r_in_ready  <= (w_next == S_FEED) && (w_rem_next != '0);
            r_core_init <= (r_state == S_INIT) && (w_next == S_WAIT_INIT);
            r_core_next <= (r_state == S_FEED) && (w_next == S_WAIT_BLK);
            r_core_done <= (r_state == S_FINAL);
            r_rem       <= w_rem_next;

            // Watchdog restarts on every state change; only wait states count.
            if (w_next != r_state) r_wd_cnt <= '0;
            else if (w_waiting)    r_wd_cnt <= r_wd_cnt + WD_W'(1);

            if (r_state == S_IDLE && w_next == S_INIT) begin
                r_core_key    <= job_key;
                r_core_nonce  <= job_nonce;
                r_core_encdec <= job_encdec;
                r_blk_cnt     <= '0;
            end

            if (r_state == S_FEED && w_next == S_WAIT_BLK) r_core_data_in <= in_data;

            if (r_state == S_WAIT_BLK && w_resp) begin
                r_out_data  <= core_data_out;
                r_out_valid <= 1'b1;
            end

            if (r_state == S_DRAIN && out_ready) begin
                r_out_valid <= 1'b0;
                r_blk_cnt   <= r_blk_cnt + NB_W'(1);
            end

            // Entering TAG_OUT from a wait state is either the real tag
            // (WAIT_TAG response) or a watchdog abort.
            if (w_waiting && w_next == S_TAG_OUT) begin
                r_tag_valid <= 1'b1;
                if (w_resp) begin
                    r_tag_out <= core_tag;
                    r_tag_err <= 1'b0;
                end else begin
                    r_tag_out <= '0;
                    r_tag_err <= 1'b1;
                end
            end

            if (r_state == S_TAG_OUT && tag_ready) r_tag_valid <= 1'b0;
        end
    end

    assign job_ready    = r_job_ready;
    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign tag_valid    = r_tag_valid;
    assign tag_out      = r_tag_out;
    assign tag_err      = r_tag_err;
    assign busy         = r_busy;
    assign blk_cnt      = r_blk_cnt;
    assign core_init    = r_core_init;
    assign core_next    = r_core_next;
    assign core_done    = r_core_done;
    assign core_encdec  = r_core_encdec;
    assign core_key     = r_core_key;
    assign core_nonce   = r_core_nonce;
    assign core_data_in = r_core_data_in;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_chacha_aead_job_sequencer.sv
// -----------------------------------------------------------------------------
// tb_chacha_aead_job_sequencer
//
// Directed bench for the AEAD job sequencer with a behavioural core model
// (fixed 20-cycle block/tag latency, optional dropped block response).
// Core model: block i output = input ^ {16{32'h1000_0000 + i}},
// tag = {key[63:0], blocks_processed[31:0], nonce[31:0]}.
// -----------------------------------------------------------------------------
module tb_chacha_aead_job_sequencer;

    localparam int LAT = 20;

    localparam logic [255:0] K1 = {4{64'h0123456789abcdef}};
    localparam logic [95:0]  N1 = {32'h11111111, 32'h22222222, 32'h33333333};
    localparam logic [255:0] K2 = {4{64'hfedcba9876543210}};
    localparam logic [95:0]  N2 = {32'h0000000a, 32'h0000000b, 32'h0000000c};
    localparam logic [511:0] D1 = {4{128'hcafebabedeadbeefcafebabedeadbeef}};
    localparam logic [511:0] D2 = {16{32'h5a5a0f0f}};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic         job_valid = 1'b0, job_ready, job_encdec = 1'b0;
    logic [255:0] job_key = '0;
    logic [95:0]  job_nonce = '0;
    logic [15:0]  job_nblocks = '0;
    logic         in_valid = 1'b0, in_ready;
    logic [511:0] in_data = '0;
    logic         out_valid, out_ready = 1'b0;
    logic [511:0] out_data;
    logic         tag_valid, tag_ready = 1'b0, tag_err;
    logic [127:0] tag_out;
    logic         busy;
    logic [15:0]  blk_cnt;
    logic         core_init, core_next, core_done, core_encdec;
    logic [255:0] core_key;
    logic [95:0]  core_nonce;
    logic [511:0] core_data_in;
    logic         core_ready, core_valid, core_tag_ok;
    logic [511:0] core_data_out;
    logic [127:0] core_tag;
    logic [3:0]   dbg_state;

    chacha_aead_job_sequencer #(.NB_W(16), .TIMEOUT(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .job_valid(job_valid), .job_ready(job_ready), .job_key(job_key),
        .job_nonce(job_nonce), .job_encdec(job_encdec), .job_nblocks(job_nblocks),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .tag_valid(tag_valid), .tag_ready(tag_ready), .tag_out(tag_out), .tag_err(tag_err),
        .busy(busy), .blk_cnt(blk_cnt),
        .core_init(core_init), .core_next(core_next), .core_done(core_done),
        .core_encdec(core_encdec), .core_key(core_key), .core_nonce(core_nonce),
        .core_data_in(core_data_in), .core_ready(core_ready), .core_valid(core_valid),
        .core_tag_ok(core_tag_ok), .core_data_out(core_data_out), .core_tag(core_tag),
        .dbg_state(dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;
    int cyc = 0, n_init = 0, n_next = 0, n_done = 0;
    int n_inrdy = 0, n_outv = 0, n_tagv = 0, n_multi = 0;
    int drop_blk = -1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (core_init) n_init <= n_init + 1;
        if (core_next) n_next <= n_next + 1;
        if (core_done) n_done <= n_done + 1;
        if (in_ready)  n_inrdy <= n_inrdy + 1;
        if (out_valid) n_outv <= n_outv + 1;
        if (tag_valid) n_tagv <= n_tagv + 1;
        if ((32'(core_init) + 32'(core_next) + 32'(core_done)) > 1) n_multi <= n_multi + 1;
    end

    // ---------------- core model ----------------
    int           m_kind, m_cnt, m_blk;
    logic [511:0] m_data;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_ready <= 1'b1; core_valid <= 1'b0; core_tag_ok <= 1'b0;
            core_data_out <= '0; core_tag <= '0;
            m_kind <= 0; m_cnt <= 0; m_blk <= 0; m_data <= '0;
        end else begin
            core_valid  <= 1'b0;
            core_tag_ok <= 1'b0;
            if (core_init) begin
                core_ready <= 1'b0; m_kind <= 1; m_cnt <= 3; m_blk <= 0;
            end else if (core_next) begin
                m_kind <= 2; m_cnt <= LAT; m_data <= core_data_in;
            end else if (core_done) begin
                m_kind <= 3; m_cnt <= LAT;
            end else if (m_kind != 0) begin
                if (m_cnt > 1) m_cnt <= m_cnt - 1;
                else begin
                    m_kind <= 0;
                    if (m_kind == 1) core_ready <= 1'b1;
                    else if (m_kind == 2) begin
                        if (m_blk != drop_blk) begin
                            core_valid    <= 1'b1;
                            core_data_out <= m_data ^ {16{32'h1000_0000 + 32'(m_blk)}};
                        end
                        m_blk <= m_blk + 1;
                    end else begin
                        core_tag_ok <= 1'b1;
                        core_tag    <= {core_key[63:0], 32'(m_blk), core_nonce[31:0]};
                    end
                end
            end
        end
    end

    // ---------------- driver tasks (all start and end on a falling edge) ----------------
    task automatic send_job(input logic [255:0] k, input logic [95:0] n, input logic e,
                            input logic [15:0] nb, input bit hold);
        int t = 0;
        job_key = k; job_nonce = n; job_encdec = e; job_nblocks = nb; job_valid = 1'b1;
        while (!job_ready && t < 2000) begin @(negedge clk); t++; end
        checks++;
        if (job_ready !== 1'b1) begin
            errors++; $display("FAIL job_accept: job_ready=%b expected 1", job_ready);
        end
        @(negedge clk);
        if (!hold) job_valid = 1'b0;
    endtask

    task automatic feed_blocks(input int nb, input logic [511:0] base,
                               input int stall_idx, input int stall_cyc);
        logic [511:0] exp_d, snap;
        int t, nn;
        bit stable;
        for (int i = 0; i < nb; i++) begin
            in_data = base; in_valid = 1'b1; t = 0;
            while (!in_ready && t < 1000) begin @(negedge clk); t++; end
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL in_ready blk %0d: got %b expected 1", i, in_ready);
            end
            @(negedge clk);
            in_valid = 1'b0; t = 0;
            while (!out_valid && t < 1000) begin @(negedge clk); t++; end
            exp_d = base ^ {16{32'h1000_0000 + 32'(i)}};
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d) begin
                errors++;
                $display("FAIL out_block %0d: valid=%b data=%h expected %h", i, out_valid, out_data, exp_d);
            end
            if (i == stall_idx) begin
                snap = out_data; nn = n_next; stable = 1'b1;
                repeat (stall_cyc) begin
                    @(negedge clk);
                    if (out_data !== snap || out_valid !== 1'b1) stable = 1'b0;
                end
                checks++;
                if (!stable) begin errors++; $display("FAIL out_hold: data/valid changed during back-pressure, expected stable"); end
                checks++;
                if (n_next != nn) begin errors++; $display("FAIL stall_core_next: %0d pulses during stall, expected 0", n_next - nn); end
                checks++;
                if (tag_valid !== 1'b0) begin errors++; $display("FAIL stall_timeout: tag_valid=%b expected 0", tag_valid); end
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic get_tag(input logic [127:0] exp_tag, input logic exp_err, input int delay);
        int t = 0;
        while (!tag_valid && t < 2000) begin @(negedge clk); t++; end
        checks++;
        if (tag_valid !== 1'b1) begin errors++; $display("FAIL tag_wait: tag_valid=%b expected 1", tag_valid); end
        checks++;
        if (tag_out !== exp_tag) begin errors++; $display("FAIL tag_value: got %h expected %h", tag_out, exp_tag); end
        checks++;
        if (tag_err !== exp_err) begin errors++; $display("FAIL tag_err: got %b expected %b", tag_err, exp_err); end
        repeat (delay) @(negedge clk);
        tag_ready = 1'b1;
        @(negedge clk);
        tag_ready = 1'b0;
        checks++;
        if (tag_valid !== 1'b0) begin errors++; $display("FAIL tag_release: tag_valid=%b expected 0", tag_valid); end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (job_ready !== 1'b1) begin errors++; $display("FAIL reset_job_ready: got %b expected 1", job_ready); end
        checks++;
        if ({busy, in_ready, out_valid, tag_valid, tag_err, core_init, core_next, core_done, core_encdec} !== 9'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 000000000",
                {busy, in_ready, out_valid, tag_valid, tag_err, core_init, core_next, core_done, core_encdec});
        end
        checks++;
        if ((|{core_key, core_nonce, core_data_in, out_data, tag_out, blk_cnt, dbg_state}) !== 1'b0) begin
            errors++; $display("FAIL reset_data: some data output nonzero, expected all 0");
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_job();
        int tv;
        send_job(K1, N1, 1'b1, 16'd4, 1'b0);
        in_data = D1; in_valid = 1'b1;
        while (!in_ready) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (dbg_state !== 4'd4) begin errors++; $display("FAIL mid_state: got %0d expected 4", dbg_state); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (job_ready !== 1'b1 || busy !== 1'b0 || core_key !== '0 || blk_cnt !== '0 || dbg_state !== 4'd0) begin
            errors++; $display("FAIL mid_reset_outputs: job_ready=%b busy=%b blk_cnt=%0d state=%0d expected 1 0 0 0",
                job_ready, busy, blk_cnt, dbg_state);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tv = n_tagv;
        repeat (60) @(negedge clk);
        checks++;
        if (n_tagv != tv || busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset_silent: tag cycles=%0d busy=%b expected 0 0", n_tagv - tv, busy);
        end
    endtask

    task automatic test_basic_job();
        int i0 = n_init, x0 = n_next, d0 = n_done;
        send_job(K1, N1, 1'b1, 16'd4, 1'b0);
        checks++;
        if (core_key !== K1 || core_nonce !== N1 || core_encdec !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL basic_latch: key=%h nonce=%h encdec=%b busy=%b", core_key, core_nonce, core_encdec, busy);
        end
        feed_blocks(4, D1, -1, 0);
        get_tag(128'h0123456789abcdef_00000004_33333333, 1'b0, 2);
        checks++;
        if (n_init - i0 != 1 || n_next - x0 != 4 || n_done - d0 != 1) begin
            errors++; $display("FAIL basic_pulses: init=%0d next=%0d done=%0d expected 1 4 1", n_init - i0, n_next - x0, n_done - d0);
        end
        checks++;
        if (blk_cnt !== 16'd4) begin errors++; $display("FAIL basic_blk_cnt: got %0d expected 4", blk_cnt); end
    endtask

    task automatic test_back_pressure();
        int x0 = n_next;
        send_job(K1, N1, 1'b1, 16'd4, 1'b0);
        feed_blocks(4, D1, 1, 50);
        get_tag(128'h0123456789abcdef_00000004_33333333, 1'b0, 0);
        checks++;
        if (n_next - x0 != 4 || blk_cnt !== 16'd4) begin
            errors++; $display("FAIL bp_counts: next=%0d blk_cnt=%0d expected 4 4", n_next - x0, blk_cnt);
        end
    endtask

    task automatic test_zero_blocks();
        int r0 = n_inrdy, o0 = n_outv, d0 = n_done;
        send_job(K1, N1, 1'b0, 16'd0, 1'b0);
        get_tag(128'h0123456789abcdef_00000000_33333333, 1'b0, 0);
        checks++;
        if (n_inrdy != r0 || n_outv != o0 || n_done - d0 != 1) begin
            errors++; $display("FAIL zero_blocks: in_ready=%0d out_valid=%0d done=%0d expected 0 0 1",
                n_inrdy - r0, n_outv - o0, n_done - d0);
        end
        checks++;
        if (blk_cnt !== 16'd0) begin errors++; $display("FAIL zero_blk_cnt: got %0d expected 0", blk_cnt); end
    endtask

    task automatic test_timeout();
        int t = 0, t0, o0 = n_outv;
        drop_blk = 0;
        send_job(K2, N2, 1'b0, 16'd2, 1'b0);
        in_data = D2; in_valid = 1'b1;
        while (!in_ready && t < 1000) begin @(negedge clk); t++; end
        @(negedge clk);
        in_valid = 1'b0;
        t0 = cyc;
        t = 0;
        while (!tag_valid && t < 500) begin @(negedge clk); t++; end
        checks++;
        if (tag_valid !== 1'b1 || cyc - t0 != 64) begin
            errors++; $display("FAIL timeout_latency: tag_valid=%b after %0d cycles expected 1 after 64", tag_valid, cyc - t0);
        end
        checks++;
        if (tag_err !== 1'b1 || tag_out !== '0) begin
            errors++; $display("FAIL timeout_tag: err=%b tag=%h expected 1 and 0", tag_err, tag_out);
        end
        checks++;
        if (n_outv != o0) begin errors++; $display("FAIL timeout_out: %0d out_valid cycles expected 0", n_outv - o0); end
        tag_ready = 1'b1;
        @(negedge clk);
        tag_ready = 1'b0;
        drop_blk = -1;
        send_job(K2, N2, 1'b0, 16'd1, 1'b0);
        feed_blocks(1, D2, -1, 0);
        get_tag(128'hfedcba9876543210_00000001_0000000c, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        send_job(K1, N1, 1'b1, 16'd1, 1'b1);
        job_key = K2; job_nonce = N2; job_encdec = 1'b0; job_nblocks = 16'd0;
        feed_blocks(1, D1, -1, 0);
        checks++;
        if (core_key !== K1 || job_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_hold: key=%h job_ready=%b expected first key and 0", core_key, job_ready);
        end
        get_tag(128'h0123456789abcdef_00000001_33333333, 1'b0, 3);
        checks++;
        if (job_ready !== 1'b1 || core_key !== K1) begin
            errors++; $display("FAIL b2b_idle: job_ready=%b key=%h expected 1 and first key", job_ready, core_key);
        end
        @(negedge clk);
        job_valid = 1'b0;
        checks++;
        if (core_key !== K2 || core_nonce !== N2 || job_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_switch: key=%h nonce=%h job_ready=%b expected second descriptor, 0",
                core_key, core_nonce, job_ready);
        end
        get_tag(128'hfedcba9876543210_00000000_0000000c, 1'b0, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_reset_mid_job();
        test_basic_job();
        test_back_pressure();
        test_zero_blocks();
        test_timeout();
        test_back_to_back();
        checks++;
        if (n_multi != 0) begin errors++; $display("FAIL pulse_overlap: %0d cycles with multiple pulses, expected 0", n_multi); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not complete, expected completion");
        $fatal(1, "bench time limit");
    end

endmodule
